// File: rtl/tile_read_scheduler.sv
// Tile-ordered frame reader: BRAM address sequencing with a credit-controlled skid FIFO.
// Optional stall counter output enabled by `define TILE_SCHED_STALL_STATS_EN.
module tile_read_scheduler #(
   parameter int IMG_WIDTH   = 32,
   parameter int IMG_HEIGHT  = 16,
   parameter int TILE_WIDTH  = 16,
   parameter int TILE_HEIGHT = 16,
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 19,
   parameter int RD_LAT      = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic              iClk,
   input  logic              iRst,
   input  logic              iStart,
   output logic [ADDR_W-1:0] oRdAddr,
   output logic              oRdEn,
   output logic              oRegCe,
   input  logic [DATA_W-1:0] iRdData,
   output logic [DATA_W-1:0] oData,
   output logic              oValid,
   input  logic              iReady,
   output logic              oTileFirst,
   output logic              oTileLast,
   output logic [15:0]       oTileIdx,
   output logic              oBusy,
   output logic              oFrameDone
`ifdef TILE_SCHED_STALL_STATS_EN
   ,
   output logic [31:0]       oStallCnt
`endif
);

   localparam int NTX   = IMG_WIDTH / TILE_WIDTH;
   localparam int NTY   = IMG_HEIGHT / TILE_HEIGHT;
   localparam int CW    = (TILE_WIDTH > 1) ? $clog2(TILE_WIDTH) : 1;
   localparam int RW    = (TILE_HEIGHT > 1) ? $clog2(TILE_HEIGHT) : 1;
   localparam int XW    = (NTX > 1) ? $clog2(NTX) : 1;
   localparam int YW    = (NTY > 1) ? $clog2(NTY) : 1;
   localparam int TW_SH = $clog2(TILE_WIDTH);
   localparam int TH_SH = $clog2(TILE_HEIGHT);
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int NW    = $clog2(FIFO_DEPTH + 1);
   localparam int LW    = $clog2(RD_LAT + 1);

   localparam logic [CW-1:0] C_MAX = CW'(TILE_WIDTH - 1);
   localparam logic [RW-1:0] R_MAX = RW'(TILE_HEIGHT - 1);
   localparam logic [XW-1:0] X_MAX = XW'(NTX - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(NTY - 1);
   localparam logic [PW-1:0] P_MAX = PW'(FIFO_DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   typedef struct packed {
      logic        first;
      logic        last;
      logic [15:0] idx;
   } side_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      side_t             side;
   } beat_t;

   state_t state_q, state_d;

   logic [CW-1:0] c_q;
   logic [RW-1:0] r_q;
   logic [XW-1:0] tx_q;
   logic [YW-1:0] ty_q;

   logic c_end, r_end, x_end, y_end, frame_end;
   logic start_acc, rd_en, credit_ok, push, pop;

   logic [ADDR_W-1:0] row, col;
   side_t             sb_cur;

   logic [RD_LAT-1:0]            v_pipe;
   side_t [RD_LAT-1:0]           sb_pipe;
   logic [LW-1:0]                inflight;

   beat_t         mem [FIFO_DEPTH];
   beat_t         head;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [NW-1:0] count_q;

   assign c_end     = (c_q == C_MAX);
   assign r_end     = (r_q == R_MAX);
   assign x_end     = (tx_q == X_MAX);
   assign y_end     = (ty_q == Y_MAX);
   assign frame_end = c_end && r_end && x_end && y_end;
   assign start_acc = (state_q == IDLE) && iStart;

   // Address from registered counters; IMG_WIDTH is a constant multiplier
   always_comb begin
      row     = (ADDR_W'(ty_q) << TH_SH) + ADDR_W'(r_q);
      col     = (ADDR_W'(tx_q) << TW_SH) + ADDR_W'(c_q);
      oRdAddr = row * ADDR_W'(IMG_WIDTH) + col;
   end

   always_comb begin
      sb_cur.first = (r_q == '0) && (c_q == '0);
      sb_cur.last  = r_end && c_end;
      sb_cur.idx   = 16'(ty_q) * 16'(NTX) + 16'(tx_q);
   end

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight = inflight + LW'(v_pipe[i]);
      end
   end

   always_comb begin
      credit_ok = (32'(inflight) + 32'(count_q) + 32'd1)
                  <= 32'(FIFO_DEPTH);
   end

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rd_en   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (iStart) state_d = RUN;
         end
         RUN: begin
            rd_en = credit_ok;
            if (credit_ok && frame_end) state_d = DRAIN;
         end
         DRAIN: begin
            if (count_q == '0 && inflight == '0) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // c fastest, then r, then tx, then ty
   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         c_q  <= '0;
         r_q  <= '0;
         tx_q <= '0;
         ty_q <= '0;
      end else if (start_acc) begin
         c_q  <= '0;
         r_q  <= '0;
         tx_q <= '0;
         ty_q <= '0;
      end else if (rd_en) begin
         c_q <= c_end ? '0 : c_q + CW'(1);
         if (c_end) begin
            r_q <= r_end ? '0 : r_q + RW'(1);
            if (r_end) begin
               tx_q <= x_end ? '0 : tx_q + XW'(1);
               if (x_end) ty_q <= y_end ? '0 : ty_q + YW'(1);
            end
         end
      end
   end

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         v_pipe  <= '0;
         sb_pipe <= '0;
      end else begin
         v_pipe[0]  <= rd_en;
         sb_pipe[0] <= sb_cur;
         for (int i = 1; i < RD_LAT; i++) begin
            v_pipe[i]  <= v_pipe[i-1];
            sb_pipe[i] <= sb_pipe[i-1];
         end
      end
   end

   assign push = v_pipe[RD_LAT-1];
   assign pop  = oValid && iReady;

   always_ff @(posedge iClk) begin
      if (push) mem[wr_ptr] <= {iRdData, sb_pipe[RD_LAT-1]};
   end

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == P_MAX) ? '0 : wr_ptr + PW'(1);
         if (pop) rd_ptr <= (rd_ptr == P_MAX) ? '0 : rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + NW'(1);
            2'b01:   count_q <= count_q - NW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Head is masked while empty so stale entries never reach the outputs
   assign head       = mem[rd_ptr];
   assign oValid     = (count_q != '0);
   assign oData      = oValid ? head.data : '0;
   assign oTileFirst = oValid && head.side.first;
   assign oTileLast  = oValid && head.side.last;
   assign oTileIdx   = oValid ? head.side.idx : '0;

   assign oRdEn      = rd_en;
   assign oBusy      = (state_q != IDLE);
   assign oRegCe     = oBusy;
   assign oFrameDone = (state_q == DONE);

`ifdef TILE_SCHED_STALL_STATS_EN
   logic [31:0] stall_q;

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         stall_q <= '0;
      end else if (start_acc) begin
         stall_q <= '0;
      end else if (oValid && !iReady && stall_q != '1) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign oStallCnt = stall_q;
`endif

endmodule

// File: tb/tb_tile_read_scheduler.sv
// Scoreboard bench for tile_read_scheduler with a 2-cycle BRAM model (mem[a]=a[7:0]).
module tb_tile_read_scheduler;

   localparam int NPIX = 512;

   typedef struct packed {
      logic [7:0]  d;
      logic        f;
      logic        l;
      logic [15:0] idx;
   } beat_t;

   logic        iClk;
   logic        iRst;
   logic        iStart;
   logic [18:0] oRdAddr;
   logic        oRdEn;
   logic        oRegCe;
   logic [7:0]  iRdData;
   logic [7:0]  oData;
   logic        oValid;
   logic        iReady;
   logic        oTileFirst;
   logic        oTileLast;
   logic [15:0] oTileIdx;
   logic        oBusy;
   logic        oFrameDone;
`ifdef TILE_SCHED_STALL_STATS_EN
   logic [31:0] oStallCnt;
`endif

   tile_read_scheduler dut (
      .iClk       (iClk),
      .iRst       (iRst),
      .iStart     (iStart),
      .oRdAddr    (oRdAddr),
      .oRdEn      (oRdEn),
      .oRegCe     (oRegCe),
      .iRdData    (iRdData),
      .oData      (oData),
      .oValid     (oValid),
      .iReady     (iReady),
      .oTileFirst (oTileFirst),
      .oTileLast  (oTileLast),
      .oTileIdx   (oTileIdx),
      .oBusy      (oBusy),
      .oFrameDone (oFrameDone)
`ifdef TILE_SCHED_STALL_STATS_EN
      ,
      .oStallCnt  (oStallCnt)
`endif
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   logic [7:0] bram_s1;
   always @(posedge iClk) begin
      if (oRdEn) bram_s1 <= oRdAddr[7:0];
      if (oRegCe) iRdData <= bram_s1;
   end

   int cyc = 0;
   always @(posedge iClk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   beat_t exp_q[$];
   beat_t rx_q[$];
   int    issued_n, max_out, stall_n, done_n;
   int    start_cyc, first_cyc, last_cyc, done_cyc;
   logic  prev_stall;
   beat_t prev_beat;

   function automatic beat_t exp_beat(input int k);
      beat_t b;
      int t, p, r, c, tx, ty, a;
      t  = k / 256;
      p  = k % 256;
      r  = p / 16;
      c  = p % 16;
      tx = t % 2;
      ty = t / 2;
      a  = (ty * 16 + r) * 32 + tx * 16 + c;
      b.d   = 8'(a);
      b.f   = (p == 0);
      b.l   = (p == 255);
      b.idx = 16'(t);
      return b;
   endfunction

   task automatic clear_stats();
      rx_q.delete();
      issued_n   = 0;
      max_out    = 0;
      stall_n    = 0;
      done_n     = 0;
      first_cyc  = -1;
      last_cyc   = -1;
      done_cyc   = -1;
      prev_stall = 1'b0;
   endtask

   // Monitor: scoreboard pop on accept, stall stability, credit bound
   initial begin
      beat_t got;
      beat_t e;
      int    out;
      prev_stall = 1'b0;
      forever begin
         @(negedge iClk);
         if (iRst === 1'b1) begin
            got = '{oData, oTileFirst, oTileLast, oTileIdx};
            if (oRdEn) issued_n++;
            out = issued_n - rx_q.size();
            if (out > max_out) max_out = out;
            if (prev_stall) begin
               checks++;
               if (oValid !== 1'b1 || got !== prev_beat) begin
                  errors++;
                  $display("FAIL stall_hold: got v=%b %h want v=1 %h",
                           oValid, got, prev_beat);
               end
            end
            if (oValid && first_cyc < 0) first_cyc = cyc;
            if (oValid && iReady) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL beat_extra: got %h want none", got);
               end else begin
                  e = exp_q.pop_front();
                  if (got !== e) begin
                     errors++;
                     $display("FAIL beat[%0d]: got %h want %h",
                              rx_q.size(), got, e);
                  end
               end
               rx_q.push_back(got);
               last_cyc = cyc;
            end
            if (oValid && !iReady) stall_n++;
            prev_stall = oValid && !iReady;
            prev_beat  = got;
            if (oFrameDone) begin
               done_n++;
               done_cyc = cyc;
            end
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   task automatic start_frame();
      @(posedge iClk);
      #1;
      clear_stats();
      for (int k = 0; k < NPIX; k++) exp_q.push_back(exp_beat(k));
      iStart    = 1'b1;
      start_cyc = cyc;
      @(posedge iClk);
      #1;
      iStart = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n;
      logic got;
      n   = 0;
      got = 1'b0;
      while (n < budget && !got) begin
         @(negedge iClk);
         #1;
         if (oFrameDone) got = 1'b1;
         n++;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no oFrameDone want one in %0d",
                  name, budget);
      end
   endtask

   task automatic check_zero_outputs(input string name);
      checks++;
      if (oRdAddr !== '0 || oRdEn !== 1'b0 || oRegCe !== 1'b0 ||
          oData !== '0 || oValid !== 1'b0 || oTileFirst !== 1'b0 ||
          oTileLast !== 1'b0 || oTileIdx !== '0 || oBusy !== 1'b0 ||
          oFrameDone !== 1'b0) begin
         errors++;
         $display("FAIL %s: got a=%h en=%b ce=%b d=%h v=%b f=%b l=%b i=%h b=%b dn=%b want all 0",
                  name, oRdAddr, oRdEn, oRegCe, oData, oValid, oTileFirst,
                  oTileLast, oTileIdx, oBusy, oFrameDone);
      end
   endtask

   task automatic test_reset();
      iRst   = 1'b0;
      iStart = 1'b0;
      iReady = 1'b1;
      clear_stats();
      repeat (3) @(posedge iClk);
      #1;
      check_zero_outputs("por_reset");
      iRst = 1'b1;
      start_frame();
      repeat (20) @(posedge iClk);
      #3;
      checks++;
      if (oValid !== 1'b1 || oBusy !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_active: got v=%b b=%b want 1 1",
                  oValid, oBusy);
      end
      iRst = 1'b0;
      exp_q.delete();
      #1;
      check_zero_outputs("async_reset");
      repeat (2) @(posedge iClk);
      #1;
      iRst     = 1'b1;
      issued_n = 0;
      repeat (8) @(posedge iClk);
      #1;
      checks++;
      if (issued_n !== 0 || oBusy !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_issue: got rd=%0d busy=%b want 0 0",
                  issued_n, oBusy);
      end
   endtask

   task automatic test_free_run();
      iReady = 1'b1;
      start_frame();
      wait_done("free", 2000);
      repeat (3) @(negedge iClk);
      #1;
      checks++;
      if (rx_q.size() !== NPIX) begin
         errors++;
         $display("FAIL free_count: got %0d want %0d", rx_q.size(), NPIX);
      end
      checks++;
      if (first_cyc - start_cyc !== 4) begin
         errors++;
         $display("FAIL free_latency: got %0d want 4", first_cyc - start_cyc);
      end
      checks++;
      if (last_cyc - first_cyc !== NPIX - 1) begin
         errors++;
         $display("FAIL free_rate: got %0d want %0d",
                  last_cyc - first_cyc, NPIX - 1);
      end
      checks++;
      if (rx_q[0].d !== 8'd0 || rx_q[15].d !== 8'd15 ||
          rx_q[16].d !== 8'd32 || rx_q[31].d !== 8'd47) begin
         errors++;
         $display("FAIL free_row_data: got %h %h %h %h want 00 0f 20 2f",
                  rx_q[0].d, rx_q[15].d, rx_q[16].d, rx_q[31].d);
      end
      checks++;
      if (rx_q[256].d !== 8'd16 || rx_q[256].f !== 1'b1 ||
          rx_q[256].idx !== 16'd1) begin
         errors++;
         $display("FAIL free_tile1: got %h want 10 f=1 idx=1", rx_q[256]);
      end
      checks++;
      if (rx_q[255].l !== 1'b1 || rx_q[511].l !== 1'b1 ||
          rx_q[254].l !== 1'b0) begin
         errors++;
         $display("FAIL free_last: got %b %b %b want 1 1 0",
                  rx_q[255].l, rx_q[511].l, rx_q[254].l);
      end
      checks++;
      if (done_cyc - last_cyc !== 2 || done_n !== 1) begin
         errors++;
         $display("FAIL free_done: got dly=%0d n=%0d want 2 1",
                  done_cyc - last_cyc, done_n);
      end
      checks++;
      if (exp_q.size() !== 0 || max_out > 4) begin
         errors++;
         $display("FAIL free_tail: got left=%0d out=%0d want 0 <=4",
                  exp_q.size(), max_out);
      end
   endtask

   task automatic test_backpressure();
      int n;
      iReady = 1'b1;
      start_frame();
      n = 0;
      while (rx_q.size() < 100 && n < 1000) begin
         @(posedge iClk);
         #1;
         n++;
      end
      iReady = 1'b0;
      repeat (10) @(posedge iClk);
      #1;
      n = 0;
      while (done_n == 0 && n < 5000) begin
         iReady = 1'($urandom_range(0, 1));
         @(posedge iClk);
         #1;
         n++;
      end
      iReady = 1'b1;
      checks++;
      if (done_n !== 1) begin
         errors++;
         $display("FAIL bp_done: got %0d want 1", done_n);
      end
      checks++;
      if (rx_q.size() !== NPIX || exp_q.size() !== 0) begin
         errors++;
         $display("FAIL bp_count: got rx=%0d left=%0d want %0d 0",
                  rx_q.size(), exp_q.size(), NPIX);
      end
      checks++;
      if (max_out !== 4) begin
         errors++;
         $display("FAIL bp_credit: got max %0d want 4", max_out);
      end
      checks++;
      if (stall_n < 10) begin
         errors++;
         $display("FAIL bp_stalls: got %0d want >=10", stall_n);
      end
`ifdef TILE_SCHED_STALL_STATS_EN
      checks++;
      if (oStallCnt !== 32'(stall_n)) begin
         errors++;
         $display("FAIL bp_stallcnt: got %0d want %0d", oStallCnt, stall_n);
      end
`endif
   endtask

   task automatic test_start_ignored();
      int n;
      iReady = 1'b1;
      start_frame();
      repeat (50) @(posedge iClk);
      #1;
      iStart = 1'b1;
      @(posedge iClk);
      #1;
      iStart = 1'b0;
      n = 0;
      while (issued_n < NPIX && n < 1000) begin
         @(posedge iClk);
         #1;
         n++;
      end
      iReady = 1'b0;
      iStart = 1'b1;
      checks++;
      if (oBusy !== 1'b1 || oRdEn !== 1'b0 || oFrameDone !== 1'b0) begin
         errors++;
         $display("FAIL drain_state: got b=%b en=%b dn=%b want 1 0 0",
                  oBusy, oRdEn, oFrameDone);
      end
      @(posedge iClk);
      #1;
      iStart = 1'b0;
      repeat (3) @(posedge iClk);
      #1;
      iReady = 1'b1;
      wait_done("ign", 200);
      checks++;
      if (done_n !== 1 || rx_q.size() !== NPIX || issued_n !== NPIX) begin
         errors++;
         $display("FAIL ign_frame: got dn=%0d rx=%0d rd=%0d want 1 %0d %0d",
                  done_n, rx_q.size(), issued_n, NPIX, NPIX);
      end
      start_frame();
      wait_done("b2b", 2000);
      repeat (5) @(posedge iClk);
      #1;
      checks++;
      if (done_n !== 1 || rx_q.size() !== NPIX || exp_q.size() !== 0) begin
         errors++;
         $display("FAIL b2b_frame: got dn=%0d rx=%0d left=%0d want 1 %0d 0",
                  done_n, rx_q.size(), exp_q.size(), NPIX);
      end
      checks++;
      if (first_cyc - start_cyc !== 4 || oBusy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_lat: got %0d busy=%b want 4 0",
                  first_cyc - start_cyc, oBusy);
      end
   endtask

   task automatic test_reset_midframe();
      int n;
      iReady = 1'b1;
      start_frame();
      n = 0;
      while (rx_q.size() < 300 && n < 1000) begin
         @(negedge iClk);
         #1;
         n++;
      end
      iRst = 1'b0;
      exp_q.delete();
      #1;
      check_zero_outputs("mid_reset");
      repeat (3) @(posedge iClk);
      #1;
      issued_n = 0;
      iRst     = 1'b1;
      repeat (6) @(posedge iClk);
      #1;
      checks++;
      if (issued_n !== 0 || oValid !== 1'b0) begin
         errors++;
         $display("FAIL mid_idle: got rd=%0d v=%b want 0 0", issued_n, oValid);
      end
      start_frame();
      wait_done("restart", 2000);
      checks++;
      if (rx_q[0] !== beat_t'{8'd0, 1'b1, 1'b0, 16'd0}) begin
         errors++;
         $display("FAIL restart_first: got %h want 00 f=1 idx=0", rx_q[0]);
      end
      checks++;
      if (rx_q.size() !== NPIX || exp_q.size() !== 0 || done_n !== 1) begin
         errors++;
         $display("FAIL restart_count: got rx=%0d left=%0d dn=%0d want %0d 0 1",
                  rx_q.size(), exp_q.size(), done_n, NPIX);
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_backpressure();
      test_start_ignored();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/tile_read_scheduler.md
# tile_read_scheduler

Sequences tile-ordered reads of a full frame from the dual-port frame-buffer BRAM's read port. It generates row/column/tile addresses and drives the BRAM enable and output-register enable. It absorbs the fixed BRAM read latency in a credit-controlled skid FIFO, so the downstream tile consumer can apply valid/ready backpressure without dropping or duplicating pixels. It sits between the frame-buffer write side (which pulses iStart once a frame is stored) and the per-tile processing pipeline.

## Interface
- IMG_WIDTH, 32, frame width in pixels (multiple of TILE_WIDTH)
- IMG_HEIGHT, 16, frame height in pixels (multiple of TILE_HEIGHT)
- TILE_WIDTH, 16, tile width (power of 2)
- TILE_HEIGHT, 16, tile height (power of 2)
- DATA_W, 8, pixel width
- ADDR_W, 19, BRAM address width; must be ≥ clog2(IMG_WIDTH*IMG_HEIGHT)
- RD_LAT, 2, BRAM read latency in cycles (2 = output register enabled)
- FIFO_DEPTH, 4, skid FIFO depth; must be ≥ RD_LAT+2
- iClk  in  1  clock
- iRst  in  1  asynchronous, active-low reset
- iStart  in  1  single-cycle pulse: read one frame
- oRdAddr  out  ADDR_W  BRAM port-B address
- oRdEn  out  1  BRAM port-B enable (read issued this cycle)
- oRegCe  out  1  BRAM output-register enable
- iRdData  in  DATA_W  BRAM port-B data, valid RD_LAT cycles after oRdEn
- oData  out  DATA_W  pixel to consumer
- oValid  out  1  oData valid
- iReady  in  1  consumer accepts when oValid&iReady
- oTileFirst  out  1  current beat is pixel (0,0) of a tile
- oTileLast  out  1  current beat is the last pixel of a tile
- oTileIdx  out  16  tile index of current beat, ty*NUM_TILES_X+tx
- oBusy  out  1  frame in progress
- oFrameDone  out  1  one-cycle pulse after the frame's last beat is accepted

## Operation
- NUM_TILES_X = IMG_WIDTH/TILE_WIDTH; NUM_TILES_Y = IMG_HEIGHT/TILE_HEIGHT.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on iStart. Counters r, c, tx, ty clear.
  - RUN→DRAIN when the last frame address issues.
  - DRAIN→DONE when the FIFO is empty and no reads are in flight.
  - DONE→IDLE unconditionally; oFrameDone=1 in DONE.
- iStart is ignored outside IDLE.
- Address: oRdAddr = (ty*TILE_HEIGHT+r)*IMG_WIDTH + tx*TILE_WIDTH + c, computed from registered counters with shifts/adds, truncated to ADDR_W.
- Counter order: c fastest, then r, then tx, then ty.
- Credit rule: issue a read (oRdEn=1) in RUN only when inflight + fifo_count + 1 ≤ FIFO_DEPTH. The FIFO therefore never overflows.
- A delayed copy of oRdEn (RD_LAT-stage shift register) writes iRdData into the FIFO.
- Tile sideband (first/last/idx) travels through the same shift register and FIFO alongside the data.
- oValid = FIFO non-empty; oData and sideband come from the FIFO head. The head pops on oValid&iReady.
- oValid, oData and sideband hold stable while oValid&!iReady.
- oRegCe = 1 whenever oBusy (any state other than IDLE).
- Reset values: oRdAddr=0, oRdEn=0, oRegCe=0, oData=0, oValid=0, oTileFirst=0, oTileLast=0, oTileIdx=0, oBusy=0, oFrameDone=0.
- Reset mid-frame: FSM→IDLE; FIFO, counters and in-flight pipeline clear; late BRAM data is discarded.

## Timing
- Cycle 0: iStart sampled.
- Cycle 1: first oRdEn with oRdAddr=0.
- Cycle 1+RD_LAT: iRdData captured into the FIFO.
- Next cycle: oValid=1. First-pixel latency is RD_LAT+2 cycles from iStart (4 by default).
- With iReady held high, throughput is 1 pixel/cycle.
- oFrameDone fires 2 cycles after the final accepted beat (DRAIN→DONE).
- After iReady deasserts, issue stops within 1 cycle, once credits are exhausted. At most FIFO_DEPTH pixels are buffered.
- Simultaneous FIFO push and pop at full or empty is legal: count is unchanged.

## Configuration
- TILE_SCHED_STALL_STATS_EN defined:
  - Adds output oStallCnt [31:0], which counts cycles with oValid&!iReady.
  - Clears on reset and on iStart accepted in IDLE; saturates at 2^32-1.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Bench BRAM model: RD_LAT=2; mem[a]=a[7:0].
- Reset: assert iRst low mid-cycle → every output is at its reset value immediately (asynchronous); no oRdEn until the next iStart.
- Default frame, iReady=1:
  - iStart → oValid first high 4 cycles later, then 512 consecutive beats.
  - Beats 0–15 carry values 0–15; beats 16–31 carry 32–47; beat 256 carries 16 with oTileFirst=1 and oTileIdx=1.
  - oTileLast on beats 255 and 511; oFrameDone pulses once.
- Backpressure:
  - iReady=0 for 10 cycles at beat 100, then random 50% iReady for the rest of the frame.
  - Received sequence equals the free-run sequence; no loss or duplicate.
  - In-flight plus buffered pixels never exceed 4.
  - oData stays stable while stalled.
- iStart pulsed during RUN and DRAIN → ignored (single frame, one oFrameDone).
  - iStart on the cycle after DONE → second identical frame.
- iRst low at beat 300, released, then iStart → new frame restarts at address 0.
  - No stale beats appear; the first new beat has oTileFirst=1, oTileIdx=0.
- TILE_SCHED_STALL_STATS_EN defined, backpressure scenario → oStallCnt equals the bench-counted stall cycles.
  - Macro undefined → the same bench minus the port passes unchanged.
